// File: rtl/image_row_packer_if.sv
// Pixel stream handshake between the binariser and the row packer.
// The source holds PixelData/PixelValid until PixelReady is seen.
interface image_row_packer_if;
  logic PixelValid;
  logic PixelData;
  logic PixelReady;

  modport master (
    output PixelValid,
    output PixelData,
    input  PixelReady
  );

  modport slave (
    input  PixelValid,
    input  PixelData,
    output PixelReady
  );
endinterface

// File: rtl/image_row_packer.sv
// Packs a raster stream of 1-bit pixels into row words for the image
// row register bank and flags completion of each frame.
module image_row_packer #(
  parameter int NrOfBits = 28,
  parameter int NrOfRows = 28,
  parameter int AddrBits = 5
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  image_row_packer_if.slave   pix,
  output logic [NrOfBits-1:0] D,
  output logic                ClockEnable,
  output logic                Tick,
  output logic [AddrBits-1:0] RowAddr,
  output logic                Busy,
  output logic                FrameDone
);

  localparam int ColBits = $clog2(NrOfBits);
  localparam logic [ColBits-1:0] LastCol =
    ColBits'(NrOfBits - 1);
  localparam logic [AddrBits-1:0] LastRow =
    AddrBits'(NrOfRows - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ColBits-1:0]    r_col;
  logic [AddrBits-1:0]   r_row;
  logic [NrOfBits-1:0]   r_shift;
  logic [NrOfBits-1:0]   r_d;
  logic [AddrBits-1:0]   r_addr;
  logic                  r_ready;
  logic                  r_ce;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_xfer;
  logic [ColBits-1:0]    w_bit;
  logic [NrOfBits-1:0]   w_shift;

  // r_ready is only ever set while in PACK
  assign w_xfer = r_ready & pix.PixelValid;
  assign w_bit  = LastCol - r_col;

  // Leftmost pixel of the row lands in the MSB
  always_comb begin
    w_shift        = r_shift;
    w_shift[w_bit] = pix.PixelData;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_shift <= '0;
      r_d     <= '0;
      r_addr  <= '0;
      r_ready <= 1'b0;
      r_ce    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ce   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state <= S_PACK;
            r_col   <= '0;
            r_row   <= '0;
            r_shift <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_PACK: begin
          if (w_xfer) begin
            r_shift <= w_shift;
            if (r_col == LastCol) begin
              r_state <= S_EMIT;
              r_col   <= '0;
              r_ready <= 1'b0;
              r_ce    <= 1'b1;
              r_d     <= w_shift;
              r_addr  <= r_row;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (r_row == LastRow) begin
            r_state <= S_DONE;
            r_row   <= '0;
            r_addr  <= '0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_PACK;
            r_row   <= r_row + 1'b1;
            r_ready <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pix.PixelReady = r_ready;
  assign D              = r_d;
  assign ClockEnable    = r_ce;
  assign Tick           = r_ce;
  assign RowAddr        = r_addr;
  assign Busy           = r_busy;
  assign FrameDone      = r_done;

endmodule

// File: tb/tb_image_row_packer.sv
// Directed, table-driven bench for image_row_packer.
// Row table gives pixel pattern, stall and the hand-computed row word.
module tb_image_row_packer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [27:0] D;
  logic        ClockEnable;
  logic        Tick;
  logic [4:0]  RowAddr;
  logic        Busy;
  logic        FrameDone;

  image_row_packer_if pif();

  image_row_packer #(
    .NrOfBits(28),
    .NrOfRows(28),
    .AddrBits(5)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .pix        (pif),
    .D          (D),
    .ClockEnable(ClockEnable),
    .Tick       (Tick),
    .RowAddr    (RowAddr),
    .Busy       (Busy),
    .FrameDone  (FrameDone)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // kind: 0 alt from 1, 1 ones, 2 zeros, 3 first only,
  // 4 last only, 5 alt from 0
  typedef struct {
    int          kind;
    int          stall_col;
    int          stall_len;
    logic [27:0] exp_d;
  } row_t;

  row_t tbl[28];

  function automatic logic pix(input int kind, input int c);
    case (kind)
      0: return (c % 2) == 0;
      1: return 1'b1;
      2: return 1'b0;
      3: return c == 0;
      4: return c == 27;
      5: return (c % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  logic [27:0] wq_d[$];
  logic [4:0]  wq_a[$];
  int          wq_c[$];
  int          dq_c[$];

  always @(negedge Clock) begin
    if (ClockEnable || Tick) begin
      chk("tick_eq_ce", 64'(Tick), 64'(ClockEnable));
      wq_d.push_back(D);
      wq_a.push_back(RowAddr);
      wq_c.push_back(cyc);
    end
    if (FrameDone) begin
      chk("busy_in_done", 64'(Busy), 64'd1);
      dq_c.push_back(cyc);
    end
  end

  function automatic logic [63:0] all_out();
    return 64'({D, ClockEnable, Tick, RowAddr,
                Busy, FrameDone, pif.PixelReady});
  endfunction

  task automatic clear_q();
    wq_d.delete();
    wq_a.delete();
    wq_c.delete();
    dq_c.delete();
  endtask

  task automatic start_frame(output int t_start);
    Start = 1'b1;
    @(posedge Clock);
    #1;
    t_start = cyc;
    Start = 1'b0;
  endtask

  task automatic wait_accept();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge Clock);
      got = pif.PixelReady;
      @(posedge Clock);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end
  endtask

  task automatic drive_pixels(input int npix, input int busy_row);
    for (int p = 0; p < npix; p++) begin
      int r;
      int c;
      r = p / 28;
      c = p % 28;
      if (c == tbl[r].stall_col) begin
        pif.PixelValid = 1'b0;
        repeat (tbl[r].stall_len) begin
          @(negedge Clock);
          chk("ready_in_stall", 64'(pif.PixelReady), 64'd1);
          @(posedge Clock);
          #1;
        end
      end
      pif.PixelValid = 1'b1;
      pif.PixelData  = pix(tbl[r].kind, c);
      if (r == busy_row && c == 5) Start = 1'b1;
      wait_accept();
      Start = 1'b0;
    end
    pif.PixelValid = 1'b0;
    pif.PixelData  = 1'b0;
  endtask

  // Called right after the last pixel edge (DUT in EMIT)
  task automatic finish_frame(input bit start_in_done);
    @(posedge Clock);
    #1;
    if (start_in_done) Start = 1'b1;
    @(negedge Clock);
    chk("done_pulse", 64'(FrameDone), 64'd1);
    @(posedge Clock);
    #1;
    Start = 1'b0;
    @(negedge Clock);
    chk("busy_fall", 64'(Busy), 64'd0);
    chk("idle_ready", 64'(pif.PixelReady), 64'd0);
    chk("done_single", 64'(FrameDone), 64'd0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("stay_idle", 64'(Busy), 64'd0);
  endtask

  task automatic check_frame(input string tag, input int t_start);
    int exp_c;
    chk({tag, "_nwrites"}, 64'(wq_d.size()), 64'd28);
    exp_c = t_start;
    for (int i = 0; i < 28; i++) begin
      exp_c += ((i == 0) ? 28 : 29) + tbl[i].stall_len;
      if (i < wq_d.size()) begin
        chk($sformatf("%s_d%0d", tag, i), 64'(wq_d[i]),
            64'(tbl[i].exp_d));
        chk($sformatf("%s_addr%0d", tag, i), 64'(wq_a[i]),
            64'(i));
        chk($sformatf("%s_cyc%0d", tag, i), 64'(wq_c[i]),
            64'(exp_c));
      end
    end
    chk({tag, "_ndone"}, 64'(dq_c.size()), 64'd1);
    if (dq_c.size() > 0)
      chk({tag, "_done_cyc"}, 64'(dq_c[0]), 64'(exp_c + 1));
  endtask

  initial begin
    int ts;

    tbl[0] = '{0, -1, 0, 28'hAAAAAAA};
    tbl[1] = '{0, 10, 5, 28'hAAAAAAA};
    tbl[2] = '{1, -1, 0, 28'hFFFFFFF};
    tbl[3] = '{2, -1, 0, 28'h0000000};
    tbl[4] = '{3, -1, 0, 28'h8000000};
    tbl[5] = '{4, -1, 0, 28'h0000001};
    tbl[6] = '{5, -1, 0, 28'h5555555};
    for (int r = 7; r < 28; r++) begin
      if (r % 2 == 0) tbl[r] = '{1, -1, 0, 28'hFFFFFFF};
      else            tbl[r] = '{2, -1, 0, 28'h0000000};
    end

    pif.PixelValid = 1'b0;
    pif.PixelData  = 1'b0;

    // Reset held, then idle with pixels offered and no Start
    repeat (3) begin
      @(negedge Clock);
      chk("in_reset", all_out(), 64'd0);
    end
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    pif.PixelValid = 1'b1;
    pif.PixelData  = 1'b1;
    repeat (10) begin
      @(negedge Clock);
      chk("idle_outs", all_out(), 64'd0);
    end
    pif.PixelValid = 1'b0;
    chk("idle_no_write", 64'(wq_d.size()), 64'd0);
    @(posedge Clock);
    #1;

    // Frame A: row patterns, stall on row 1
    clear_q();
    start_frame(ts);
    drive_pixels(28 * 28, -1);
    finish_frame(1'b0);
    check_frame("A", ts);

    // Frame B: Start during row 3 and during DONE are ignored
    clear_q();
    start_frame(ts);
    drive_pixels(28 * 28, 3);
    finish_frame(1'b1);
    check_frame("B", ts);

    // Reset in row 1, column 12
    clear_q();
    start_frame(ts);
    drive_pixels(40, -1);
    #2;
    Reset = 1'b0;
    #1;
    chk("abort_outs", all_out(), 64'd0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    pif.PixelValid = 1'b1;
    repeat (2) begin
      @(negedge Clock);
      chk("post_abort_idle", all_out(), 64'd0);
    end
    pif.PixelValid = 1'b0;
    chk("abort_one_write", 64'(wq_d.size()), 64'd1);
    @(posedge Clock);
    #1;

    // Frame C: clean frame after abort
    clear_q();
    start_frame(ts);
    drive_pixels(28 * 28, -1);
    finish_frame(1'b0);
    check_frame("C", ts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
